dmem_responder: RTL
===================

# dmem_responder

Word-organised data-memory responder serving the memory stage's dcache port (`r_enable`/`r_addr`/`r_data`, `w_enable`/`w_addr`/`w_data`). It sits directly below the memory stage:
- combinational word read, used for both loads and the read half of sub-word read-modify-write stores;
- clocked full-word write of the pre-merged word;
- optional post-reset clear sequencer, address-range fault reporting and saturating access counters.

## Interface
Parameters:
- `ADDR_W`, 10: word-index width; `DEPTH` = 2**`ADDR_W` words.
- `BASE`, 32'h00000000: byte address of word 0; must be `DEPTH*4`-aligned.

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset; asynchronous, active-low.
- `r_enable`  in  1  read request, sampled combinationally.
- `r_addr`  in  32  read byte address; bits [1:0] ignored.
- `r_data`  out  32  read word, combinational.
- `w_enable`  in  1  write request.
- `w_addr`  in  32  write byte address; bits [1:0] ignored.
- `w_data`  in  32  full word to store (initiator has already merged byte/half lanes).
- `busy`  out  1  clear sequence in progress; accesses not serviced.
- `fault`  out  1  one-cycle pulse: an access in the previous cycle was out of range.
- `fault_addr`  out  32  byte address of the most recent faulting access.
- `rd_count`  out  32  accepted reads, saturating.
- `wr_count`  out  32  accepted writes, saturating.

## Operation
- Offset = `addr - BASE`. In range iff offset[31:`ADDR_W`+2] == 0. Index = offset[`ADDR_W`+1:2].
- State machine: `CLEAR` → `READY`. Reset forces `CLEAR`, or `READY` when the macro is absent.
- `CLEAR` state:
  - `clr_ptr` starts at 0. Each cycle writes 0 to `mem[clr_ptr]` and increments `clr_ptr`.
  - On the cycle `clr_ptr == DEPTH-1`, that word is written and `READY` is entered at the same edge.
  - `busy` = 1. Requests are ignored: no write, no count, no fault, `r_data` = 0.
- `READY` state:
  - `busy` = 0.
  - Read: `r_data` = `mem[index]` when `r_enable` is high and the address is in range; otherwise 0.
  - Write: `mem[index]` <= `w_data` at the posedge when `w_enable` is high and the address is in range.
- Read and write in the same cycle:
  - `r_data` shows the pre-write contents, even at the same index. This is required for read-modify-write.
  - Both accesses are counted.
- Out-of-range access while `READY`:
  - Reads return 0; writes are dropped.
  - `fault` is 1 in the following cycle.
  - `fault_addr` <= the offending address. If both ports fault in the same cycle, the write address wins.
  - `fault_addr` holds its value until the next fault.
- Counters:
  - `rd_count` += 1 per in-range `r_enable` cycle; `wr_count` += 1 per in-range `w_enable` cycle.
  - Both stick at 32'hFFFFFFFF.
- No internal stall or flush: every `READY`-state request completes in its own cycle.

## Timing
- Reset values: `fault` 0, `fault_addr` 0, `rd_count` 0, `wr_count` 0, `clr_ptr` 0.
- `busy` after reset: 1 with the macro, 0 without.
- Read latency: 0 cycles (combinational from `r_addr`/`r_enable`).
- Write latency: visible on `r_data` the cycle after the write edge.
- `fault`: asserted exactly 1 cycle after the faulting request; lasts 1 cycle per faulting cycle.
- `busy` high for exactly `DEPTH` cycles after `rst` deasserts (macro on).
- `rst` asserted mid-`CLEAR` or mid-operation:
  - Immediate async return to reset values.
  - `CLEAR` restarts from `clr_ptr` 0.
  - Array contents are not reset asynchronously.

## Configuration
- `DMEM_CLEAR_ON_RESET_EN`:
  - Defined: the `CLEAR` state and `clr_ptr` are present, and the array reads all-zero once `busy` falls.
  - Undefined: no `CLEAR` logic. Reset enters `READY` directly, `busy` is tied to 0, and array contents after reset are undefined.

## Test plan
- Reset release, macro on, `ADDR_W`=4: `busy`=1 for 16 cycles, then 0; reads of indices 0..15 return 0; counters 0.
- Write 32'hDEADBEEF to 0x8, read 0x8 and 0xB next cycle → both 32'hDEADBEEF; `wr_count`=1, `rd_count`=2.
- Same cycle: read and write 0x8 with 32'h12345678 (old 32'hDEADBEEF) → `r_data` 32'hDEADBEEF that cycle, 32'h12345678 the next.
- Write to `BASE`+`DEPTH`*4 → `fault`=1 next cycle only; `fault_addr` = that address; no array change; `wr_count` unchanged.
- Requests during `busy` → `r_data`=0, no writes, counters 0, `fault` 0; `rst` pulsed mid-clear → `busy` held another full 16 cycles.
- Force `rd_count` to 32'hFFFFFFFE, then 3 reads → `rd_count` 32'hFFFFFFFF, stays.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory sitting under the memory stage's
// dcache port. Reads are combinational (and show pre-write contents when a
// write lands on the same index in the same cycle, which is what sub-word
// read-modify-write stores rely on). Writes store the already-merged full word
// at the clock edge. Out-of-range accesses are dropped and reported on a
// one-cycle fault pulse, and accepted accesses feed saturating counters.
//
// Build option: define DMEM_CLEAR_ON_RESET_EN to include the post-reset clear
// sequencer (CLEAR state walking clr_ptr over every word). Without it, reset
// goes straight to READY, busy is tied low, and array contents after reset
// are whatever the storage happens to hold.

module dmem_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_enable,
  input  logic [31:0] r_addr,
  output logic [31:0] r_data,
  input  logic        w_enable,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       rOff;
  logic [31:0]       wOff;
  logic              rInRange;
  logic              wInRange;
  logic [ADDR_W-1:0] rIdx;
  logic [ADDR_W-1:0] wIdx;

  logic              ready;
  logic              rdAccept;
  logic              wrAccept;
  logic              rdFault;
  logic              wrFault;

  logic              fault_q;
  logic              fault_d;
  logic [31:0]       faultAddr_q;
  logic [31:0]       faultAddr_d;
  logic [31:0]       rdCount_q;
  logic [31:0]       rdCount_d;
  logic [31:0]       wrCount_q;
  logic [31:0]       wrCount_d;

  logic              unusedByteLanes;

  // Addresses are relative to BASE; anything with bits set above the word
  // index field lies outside the array. The byte-lane bits are not needed
  // because the initiator always hands over whole words.
  assign rOff     = r_addr - BASE;
  assign wOff     = w_addr - BASE;
  assign rInRange = (rOff[31:ADDR_W+2] == '0);
  assign wInRange = (wOff[31:ADDR_W+2] == '0);
  assign rIdx     = rOff[ADDR_W+1:2];
  assign wIdx     = wOff[ADDR_W+1:2];
  assign unusedByteLanes = ^{rOff[1:0], wOff[1:0]};

`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clrPtr_q;
  logic [ADDR_W-1:0] clrPtr_d;
  logic              clearing;

  // State register and clear pointer; reset always restarts the sweep at word 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_CLEAR;
      clrPtr_q <= '0;
    end else begin
      state_q  <= state_d;
      clrPtr_q <= clrPtr_d;
    end
  end

  // Walk the pointer once over the array and leave CLEAR on the edge that
  // zeroes the last word.
  always_comb begin
    state_d  = state_q;
    clrPtr_d = clrPtr_q;
    case (state_q)
      ST_CLEAR: begin
        clrPtr_d = clrPtr_q + 1'b1;
        if (clrPtr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  // Decode the state into the service-enable and clear-write strobes.
  always_comb begin
    ready    = (state_q == ST_READY);
    clearing = (state_q == ST_CLEAR);
  end
`else
  assign ready = 1'b1;
`endif

  assign rdAccept = ready & r_enable & rInRange;
  assign wrAccept = ready & w_enable & wInRange;
  assign rdFault  = ready & r_enable & ~rInRange;
  assign wrFault  = ready & w_enable & ~wInRange;

  // Combinational read port; the array is only updated at the edge, so a
  // same-cycle write to the same word still returns the old contents here.
  always_comb begin
    r_data = '0;
    if (rdAccept) begin
      r_data = mem[rIdx];
    end
  end

  // Storage array: no reset on the contents, only the clear sweep or an
  // accepted write changes a word.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (clearing) begin
      mem[clrPtr_q] <= '0;
    end else if (wrAccept) begin
      mem[wIdx] <= w_data;
    end
`else
    if (wrAccept) begin
      mem[wIdx] <= w_data;
    end
`endif
  end

  // Next-state for fault reporting and saturating counters; the write address
  // takes priority when both ports fault together.
  always_comb begin
    fault_d     = rdFault | wrFault;
    faultAddr_d = faultAddr_q;
    if (wrFault) begin
      faultAddr_d = w_addr;
    end else if (rdFault) begin
      faultAddr_d = r_addr;
    end
    rdCount_d = rdCount_q;
    if (rdAccept && (rdCount_q != 32'hFFFF_FFFF)) begin
      rdCount_d = rdCount_q + 32'd1;
    end
    wrCount_d = wrCount_q;
    if (wrAccept && (wrCount_q != 32'hFFFF_FFFF)) begin
      wrCount_d = wrCount_q + 32'd1;
    end
  end

  // Status registers, all returned to zero by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q     <= 1'b0;
      faultAddr_q <= '0;
      rdCount_q   <= '0;
      wrCount_q   <= '0;
    end else begin
      fault_q     <= fault_d;
      faultAddr_q <= faultAddr_d;
      rdCount_q   <= rdCount_d;
      wrCount_q   <= wrCount_d;
    end
  end

  assign busy       = ~ready;
  assign fault      = fault_q;
  assign fault_addr = faultAddr_q;
  assign rd_count   = rdCount_q;
  assign wr_count   = wrCount_q;

endmodule
